mem_access_unit: RTL and testbench

Parametrised successor to the processor's MAR/MDR memory bus controller. Holds the memory address register (MAR) and memory data register (MDR), and runs one memory transaction per command from the control FSM. Memory handshakes with a variable wait-state `mem_req`/`mem_ack` protocol and a bounded timeout. The internal data bus is driven via an explicit output-enable, with no internal tristates; it sits between the control FSM, the internal data bus and main memory.

---
 rtl/mau_pkg.sv | 14 +
 rtl/wait_timer.sv | 32 +++
 rtl/mem_access_unit.sv | 97 +++++++++
 tb/tb_mem_access_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared types and helpers for the memory access unit
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - wait-state down-counter; expired marks the last allowed REQ cycle
module wait_timer
  import mau_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Loaded with TIMEOUT-1 on accept, so it reads zero in the TIMEOUT-th REQ cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MAR/MDR holder running one req/ack memory transaction per command
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_marce,
  input  logic              i_mdrce,
  input  logic              i_mdroe,
  input  logic [DATA_W-1:0] i_bus_in,
  output logic [DATA_W-1:0] o_bus_out,
  output logic              o_bus_oe,
  input  logic              i_cmd_valid,
  input  logic              i_cmd_write,
  output logic              o_cmd_ready,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack
);

  mau_state_t        r_state;
  mau_state_t        w_next;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_we;
  logic              r_err;
  logic              w_idle;
  logic              w_accept;
  logic              w_timer_en;
  logic              w_expired;

  assign w_idle     = (r_state == IDLE);
  assign w_accept   = w_idle && i_cmd_valid;
  assign w_timer_en = (r_state == REQ) && !i_mem_ack;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_accept),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_cmd_valid) w_next = REQ;
      REQ:     if (i_mem_ack || w_expired) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Register loads only in IDLE, so address and write data hold steady across REQ.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mar <= '0;
      r_mdr <= '0;
      r_we  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_idle && i_marce) r_mar <= i_bus_in[ADDR_W-1:0];
      if (w_idle && i_mdrce) r_mdr <= i_bus_in;
      if (w_accept) r_we <= i_cmd_write;
      if ((r_state == REQ) && i_mem_ack && !r_we) r_mdr <= i_mem_rdata;
      if (r_state == REQ) r_err <= !i_mem_ack && w_expired;
    end
  end

  assign o_cmd_ready = w_idle;
  assign o_mem_req   = (r_state == REQ);
  assign o_mem_we    = (r_state == REQ) && r_we;
  assign o_done      = (r_state == DONE);
  assign o_err       = (r_state == DONE) && r_err;
  assign o_mem_addr  = r_mar;
  assign o_mem_wdata = r_mdr;
  assign o_bus_out   = r_mdr;
  assign o_bus_oe    = i_mdroe && w_idle;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              marce, mdrce, mdroe;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              cmd_valid, cmd_write, cmd_ready;
  logic              done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req, mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_marce     (marce),
    .i_mdrce     (mdrce),
    .i_mdroe     (mdroe),
    .i_bus_in    (bus_in),
    .o_bus_out   (bus_out),
    .o_bus_oe    (bus_oe),
    .i_cmd_valid (cmd_valid),
    .i_cmd_write (cmd_write),
    .o_cmd_ready (cmd_ready),
    .o_done      (done),
    .o_err       (err),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_regs(input logic [15:0] mar, input logic [15:0] mdr);
    marce = 1'b1; mdrce = 1'b0; bus_in = mar;
    tick();
    marce = 1'b0; mdrce = 1'b1; bus_in = mdr;
    tick();
    mdrce = 1'b0; bus_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; marce = 0; mdrce = 0; mdroe = 1; bus_in = '0;
    cmd_valid = 0; cmd_write = 0; mem_rdata = '0; mem_ack = 0;
    tick();
    checks++;
    if ({mem_req, mem_we, done, err, cmd_ready, bus_oe} !== 6'b000011) begin
      errors++; $display("FAIL reset_ctrl got %b exp 000011", {mem_req, mem_we, done, err, cmd_ready, bus_oe});
    end
    checks++;
    if ({mem_addr, mem_wdata, bus_out} !== 48'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, bus_out});
    end
    mdroe = 0;
    #1;
    checks++;
    if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe_off got %b exp 0", bus_oe); end
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_read();
    load_regs(16'h0042, 16'h5555);
    cmd_valid = 1; cmd_write = 0;
    tick();
    cmd_valid = 0;
    checks++;
    if ({mem_req, mem_we, cmd_ready, mem_addr} !== {3'b100, 16'h0042}) begin
      errors++; $display("FAIL zw_req got %b %h exp 100 0042", {mem_req, mem_we, cmd_ready}, mem_addr);
    end
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 0; mem_rdata = '0;
    checks++;
    if ({done, err, mem_req, bus_out} !== {3'b100, 16'hBEEF}) begin
      errors++; $display("FAIL zw_done got %b %h exp 100 beef", {done, err, mem_req}, bus_out);
    end
    tick();
    checks++;
    if ({done, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL zw_idle got %b exp 01", {done, cmd_ready});
    end
  endtask

  task automatic test_wait_write();
    int held = 0;
    load_regs(16'h1000, 16'h1234);
    cmd_valid = 1; cmd_write = 1;
    tick();
    cmd_valid = 0; cmd_write = 0;
    for (int k = 1; k <= 4; k++) begin
      if (mem_req && mem_we && mem_addr == 16'h1000 && mem_wdata == 16'h1234 && !done) held++;
      if (k == 4) mem_ack = 1;
      tick();
    end
    mem_ack = 0;
    checks++;
    if (held !== 4) begin errors++; $display("FAIL wr_hold got %0d exp 4", held); end
    checks++;
    if ({done, err, mem_req} !== 3'b100) begin
      errors++; $display("FAIL wr_done got %b exp 100", {done, err, mem_req});
    end
    checks++;
    if (bus_out !== 16'h1234) begin errors++; $display("FAIL wr_mdr got %h exp 1234", bus_out); end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    int dones = 0;
    load_regs(16'h0007, 16'hA5A5);
    mem_rdata = 16'hDEAD;
    cmd_valid = 1; cmd_write = 0;
    tick();
    cmd_valid = 0;
    while (mem_req && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n !== TIMEOUT) begin errors++; $display("FAIL to_req_cycles got %0d exp %0d", n, TIMEOUT); end
    checks++;
    if ({done, err} !== 2'b11) begin errors++; $display("FAIL to_done_err got %b exp 11", {done, err}); end
    checks++;
    if (bus_out !== 16'hA5A5) begin errors++; $display("FAIL to_mdr got %h exp a5a5", bus_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL to_single_pulse got %0d exp 0", dones); end
    mem_rdata = '0;
  endtask

  task automatic test_ack_last();
    int n = 0;
    cmd_valid = 1; cmd_write = 0;
    tick();
    cmd_valid = 0;
    while (mem_req && n < 20) begin
      n++;
      if (n == TIMEOUT) begin mem_ack = 1; mem_rdata = 16'hCAFE; end
      tick();
    end
    mem_ack = 0; mem_rdata = '0;
    checks++;
    if (n !== TIMEOUT) begin errors++; $display("FAIL last_req_cycles got %0d exp %0d", n, TIMEOUT); end
    checks++;
    if ({done, err, bus_out} !== {2'b10, 16'hCAFE}) begin
      errors++; $display("FAIL last_ack got %b %h exp 10 cafe", {done, err}, bus_out);
    end
    tick();
  endtask

  task automatic test_busy_loads();
    int dones = 0;
    load_regs(16'h0123, 16'h4567);
    cmd_valid = 1; cmd_write = 1;
    tick();
    marce = 1; mdrce = 1; mdroe = 1; bus_in = 16'hFFFF;
    #1;
    checks++;
    if ({bus_oe, cmd_ready, mem_req} !== 3'b001) begin
      errors++; $display("FAIL busy_oe got %b exp 001", {bus_oe, cmd_ready, mem_req});
    end
    tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    if (done) dones++;
    marce = 0; mdrce = 0; cmd_valid = 0; cmd_write = 0; bus_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) dones++;
    end
    checks++;
    if ({mem_addr, mem_wdata} !== {16'h0123, 16'h4567}) begin
      errors++; $display("FAIL busy_regs got %h %h exp 0123 4567", mem_addr, mem_wdata);
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL busy_txn_count got %0d exp 1", dones); end
    checks++;
    if (bus_oe !== 1'b1) begin errors++; $display("FAIL idle_oe got %b exp 1", bus_oe); end
    mdroe = 0;
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    cmd_valid = 1; cmd_write = 0; mem_ack = 1; mem_rdata = 16'h0F0F;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done) dones++;
    end
    cmd_valid = 0;
    checks++;
    if (dones !== 3) begin errors++; $display("FAIL b2b_dones got %0d exp 3", dones); end
    tick();
    tick();
    mem_ack = 0; mem_rdata = '0;
    checks++;
    if ({cmd_ready, bus_out} !== {1'b1, 16'h0F0F}) begin
      errors++; $display("FAIL b2b_end got %b %h exp 1 0f0f", cmd_ready, bus_out);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    load_regs(16'h0099, 16'h7777);
    cmd_valid = 1; cmd_write = 1;
    tick();
    cmd_valid = 0; cmd_write = 0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, done, cmd_ready} !== 4'b0001) begin
      errors++; $display("FAIL rstmid_ctrl got %b exp 0001", {mem_req, mem_we, done, cmd_ready});
    end
    checks++;
    if ({mem_addr, bus_out} !== 32'h0) begin
      errors++; $display("FAIL rstmid_regs got %h %h exp 0 0", mem_addr, bus_out);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || mem_req) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", dones); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_timeout();
    test_ack_last();
    test_busy_loads();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
